// File: rtl/bdaq53_eth_data_core_if.sv
// bdaq53_eth_data_core_if: FIFO-side handshake of the Ethernet test-data source.
interface bdaq53_eth_data_core_if;
  logic        fifo_full;
  logic [31:0] FIFO_DATA;
  logic        FIFO_WRITE;
  modport master (input fifo_full, output FIFO_DATA, FIFO_WRITE);
  modport slave  (output fifo_full, input FIFO_DATA, FIFO_WRITE);
endinterface

// File: rtl/bdaq53_eth_data_core.sv
// bdaq53_eth_data_core: register-controlled incrementing-counter source feeding the readout FIFO.
module bdaq53_eth_data_core #(
  parameter logic [31:0] BASEADDR  = 32'h1000,
  parameter logic [31:0] HIGHADDR  = 32'h1FFF,
  parameter int          ABUSWIDTH = 32,
  parameter logic [7:0]  VERSION   = 8'd1
) (
  input  logic                   BUS_CLK,
  input  logic                   RESET_N,
  input  logic                   PLL_LOCKED,
  input  logic [ABUSWIDTH-1:0]   BUS_ADD,
  inout  wire  [31:0]            BUS_DATA,
  input  logic                   BUS_RD,
  input  logic                   BUS_WR,
  bdaq53_eth_data_core_if.master fifo,
  output logic [7:0]             GPIO
);
  logic [ABUSWIDTH-1:0] off;
  logic                 in_range, hit, wr_en, rd_en, soft_rst, fire;
  logic [3:0]           sel;
  logic [7:0]           wdata, rd_byte, rdata_q, gpio_q, gpio_d;
  logic                 en_q, en_d, oe_q;
  logic [31:0]          limit_q, limit_d, cnt_q, cnt_d, snap_q, snap_d;

  assign off      = BUS_ADD - ABUSWIDTH'(BASEADDR);
  assign in_range = BUS_ADD >= ABUSWIDTH'(BASEADDR) && BUS_ADD <= ABUSWIDTH'(HIGHADDR);
  assign hit      = in_range && off < ABUSWIDTH'(11);
  assign sel      = off[3:0];
  assign wdata    = BUS_DATA[7:0];
  assign wr_en    = BUS_WR && hit;
  assign rd_en    = BUS_RD && in_range;
  assign soft_rst = wr_en && sel == 4'd0;
  // LIMIT of zero means free-running; otherwise stall once CNT reaches it
  assign fire     = en_q && PLL_LOCKED && !fifo.fifo_full && (limit_q == '0 || cnt_q != limit_q);

  assign fifo.FIFO_WRITE = fire;
  assign fifo.FIFO_DATA  = cnt_q;
  assign GPIO            = gpio_q;
  assign BUS_DATA        = {24'bz, (oe_q && BUS_RD) ? rdata_q : 8'bz};

  always_comb begin
    rd_byte = '0;
    if (hit)
      case (sel)
        4'd0:    rd_byte = VERSION;
        4'd1:    rd_byte = {7'b0, en_q};
        4'd2:    rd_byte = gpio_q;
        4'd3:    rd_byte = limit_q[7:0];
        4'd4:    rd_byte = limit_q[15:8];
        4'd5:    rd_byte = limit_q[23:16];
        4'd6:    rd_byte = limit_q[31:24];
        4'd7:    rd_byte = cnt_q[7:0];
        4'd8:    rd_byte = snap_q[15:8];
        4'd9:    rd_byte = snap_q[23:16];
        4'd10:   rd_byte = snap_q[31:24];
        default: rd_byte = '0;
      endcase
  end

  always_comb begin
    en_d    = en_q;
    gpio_d  = gpio_q;
    limit_d = limit_q;
    snap_d  = (rd_en && hit && sel == 4'd7) ? cnt_q : snap_q;
    cnt_d   = fire ? cnt_q + 32'd1 : cnt_q;
    if (wr_en)
      case (sel)
        4'd1:    en_d = wdata[0];
        4'd2:    gpio_d = wdata;
        4'd3:    limit_d[7:0] = wdata;
        4'd4:    limit_d[15:8] = wdata;
        4'd5:    limit_d[23:16] = wdata;
        4'd6:    limit_d[31:24] = wdata;
        default: ;
      endcase
    // soft reset overrides any increment or register update in the same cycle
    if (soft_rst) begin
      en_d    = 1'b0;
      gpio_d  = '0;
      limit_d = '0;
      snap_d  = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge BUS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      en_q    <= 1'b0;
      gpio_q  <= '0;
      limit_q <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      en_q    <= en_d;
      gpio_q  <= gpio_d;
      limit_q <= limit_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      oe_q    <= rd_en;
      if (rd_en) rdata_q <= rd_byte;
    end
  end
endmodule

// File: tb/tb_bdaq53_eth_data_core.sv
// tb_bdaq53_eth_data_core: randomized bus/backpressure stimulus checked against a word-stream model.
module tb_bdaq53_eth_data_core;
  localparam logic [31:0] BASE = 32'h1000;
  logic        clk = 0, rst_n = 0, pll = 0, rd = 0, wr = 0, drv_en = 0, full = 0;
  logic        rand_on = 0, mon_on = 0, en_m = 0, ew;
  logic [31:0] add = 0, lim_m = 0, next_m = 0, cnt_rd, target;
  logic [7:0]  drv = 0, gpio, rb, gpio_m = 0, v8;
  wire  [31:0] bus_data;
  int          tests = 0, fails = 0;

  bdaq53_eth_data_core_if ff();
  assign ff.fifo_full = full;
  assign bus_data = drv_en ? {24'h0, drv} : 32'bz;
  always #5 clk = ~clk;

  bdaq53_eth_data_core dut (
    .BUS_CLK(clk), .RESET_N(rst_n), .PLL_LOCKED(pll), .BUS_ADD(add), .BUS_DATA(bus_data),
    .BUS_RD(rd), .BUS_WR(wr), .fifo(ff.master), .GPIO(gpio)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    en_m = 0; gpio_m = 0; lim_m = 0; next_m = 0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    add = a; drv = d; drv_en = 1; wr = 1;
    @(posedge clk); #1;
    wr = 0; drv_en = 0;
    if (a >= BASE && a <= BASE + 32'hFFF)
      case (a - BASE)
        32'd0: model_reset();
        32'd1: en_m = d[0];
        32'd2: gpio_m = d;
        32'd3: lim_m[7:0] = d;
        32'd4: lim_m[15:8] = d;
        32'd5: lim_m[23:16] = d;
        32'd6: lim_m[31:24] = d;
        default: ;
      endcase
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    add = a; rd = 1;
    @(posedge clk);
    @(negedge clk);
    d = bus_data[7:0];
    rd = 0;
  endtask

  task automatic read_count(output logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    bus_rd(BASE + 7, b0); bus_rd(BASE + 8, b1);
    bus_rd(BASE + 9, b2); bus_rd(BASE + 10, b3);
    c = {b3, b2, b1, b0};
  endtask

  task automatic write_limit(input logic [31:0] l);
    bus_wr(BASE + 3, l[7:0]); bus_wr(BASE + 4, l[15:8]);
    bus_wr(BASE + 5, l[23:16]); bus_wr(BASE + 6, l[31:24]);
  endtask

  // Model: stream is 0,1,2,... one word per cycle whenever enabled, locked, not full and below limit
  always @(negedge clk) if (rst_n && mon_on) begin
    ew = en_m && pll && !full && (lim_m == 0 || next_m != lim_m);
    chk("fifo_write", {31'b0, ff.FIFO_WRITE}, {31'b0, ew});
    if (ew) begin
      chk("fifo_data", ff.FIFO_DATA, next_m);
      next_m = next_m + 1;
    end
  end

  always @(posedge clk) if (rand_on) begin
    #1;
    full = $urandom_range(0, 3) == 0;
    pll  = $urandom_range(0, 7) != 0;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", {31'b0, ff.FIFO_WRITE}, 0);
    chk("rst_data", ff.FIFO_DATA, 0);
    chk("rst_gpio", {24'b0, gpio}, 0);
    rst_n = 1; mon_on = 1;
    bus_rd(BASE + 0, rb); chk("version", {24'b0, rb}, 32'h01);
    bus_rd(BASE + 1, rb); chk("ctrl_rst", {24'b0, rb}, 0);
    bus_rd(BASE + 2, rb); chk("gpio_rst", {24'b0, rb}, 0);

    bus_wr(BASE + 2, 8'hA5);
    chk("gpio_out", {24'b0, gpio}, 32'hA5);
    bus_rd(BASE + 2, rb); chk("gpio_rd", {24'b0, rb}, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      v8 = 8'($urandom);
      bus_wr(BASE + 2, v8);
      chk("gpio_rand", {24'b0, gpio}, {24'b0, gpio_m});
      bus_rd(BASE + 2, rb); chk("gpio_rand_rd", {24'b0, rb}, {24'b0, v8});
    end
    bus_wr(32'h0000_0002, 8'h3C);
    chk("gpio_out_of_range", {24'b0, gpio}, {24'b0, gpio_m});
    bus_wr(BASE + 11, 8'h3C);
    chk("gpio_unmapped", {24'b0, gpio}, {24'b0, gpio_m});
    bus_rd(BASE + 11, rb); chk("rd_unmapped", {24'b0, rb}, 0);
    bus_rd(BASE + 32'hFFF, rb); chk("rd_high", {24'b0, rb}, 0);

    pll = 1; full = 0;
    bus_wr(BASE + 1, 8'h01);
    repeat (100) @(posedge clk);
    bus_wr(BASE + 1, 8'h00);
    repeat (2) @(posedge clk);
    read_count(cnt_rd);
    chk("count_free", cnt_rd, next_m);
    chk("count_ge100", {31'b0, cnt_rd >= 100}, 1);

    bus_wr(BASE + 1, 8'h01);
    repeat (20) @(posedge clk);
    #1 full = 1;
    repeat (10) @(posedge clk);
    #1 full = 0;
    repeat (20) @(posedge clk);
    rand_on = 1;
    repeat (300) @(posedge clk);
    rand_on = 0;
    @(posedge clk); #1 full = 0; pll = 1;
    bus_wr(BASE + 1, 8'h00);
    repeat (2) @(posedge clk);
    read_count(cnt_rd);
    chk("count_random", cnt_rd, next_m);

    bus_wr(BASE + 0, 8'hFF);
    read_count(cnt_rd); chk("count_soft_rst", cnt_rd, 0);
    write_limit(32'd16);
    bus_wr(BASE + 1, 8'h01);
    repeat (40) @(posedge clk);
    read_count(cnt_rd); chk("count_limit16", cnt_rd, 32'd16);
    chk("limit_stall", {31'b0, ff.FIFO_WRITE}, 0);
    bus_rd(BASE + 1, rb); chk("en_kept", {24'b0, rb}, 1);
    bus_wr(BASE + 3, 8'd20);
    repeat (20) @(posedge clk);
    read_count(cnt_rd); chk("count_limit20", cnt_rd, 32'd20);

    target = 32'd20 + $urandom_range(5, 60);
    write_limit(target);
    rand_on = 1;
    repeat (150) @(posedge clk);
    rand_on = 0;
    @(posedge clk); #1 full = 0; pll = 1;
    repeat (80) @(posedge clk);
    read_count(cnt_rd); chk("count_limit_rand", cnt_rd, target);

    write_limit(32'd0);
    repeat (30) @(posedge clk);
    bus_wr(BASE + 0, 8'h00);
    chk("soft_rst_write", {31'b0, ff.FIFO_WRITE}, 0);
    bus_rd(BASE + 1, rb); chk("soft_rst_en", {24'b0, rb}, 0);
    bus_rd(BASE + 3, rb); chk("soft_rst_limit", {24'b0, rb}, 0);
    read_count(cnt_rd); chk("soft_rst_count", cnt_rd, 0);
    bus_wr(BASE + 1, 8'h01);
    repeat (10) @(posedge clk);

    bus_wr(BASE + 2, 8'h5A);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("async_rst_write", {31'b0, ff.FIFO_WRITE}, 0);
    chk("async_rst_data", ff.FIFO_DATA, 0);
    chk("async_rst_gpio", {24'b0, gpio}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    bus_wr(BASE + 1, 8'h01);
    repeat (10) @(posedge clk);
    bus_wr(BASE + 1, 8'h00);
    repeat (2) @(posedge clk);
    read_count(cnt_rd); chk("count_after_rst", cnt_rd, next_m);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
